hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Interlock unit between fetch/decode and the rest of the 5-phase pipeline (FETCH, REG, EXEC, MEM, WB).
- Tracks in-flight instructions in a 4-slot scoreboard shift register (S1=REG, S2=EXEC, S3=MEM, S4=WB).
- Generates `stall_bits` for the fetch stage and inserts bubbles on read-after-write (RAW), flag and PC hazards. There is no forwarding.
- Also supplies the WB-slot write qualifiers and a saturating stall counter for the debug ports.

Parameters:
- PHASES, 5, number of pipeline phases; width of `stall_bits`.
- REGAW, 4, register address width.
- FLAGS_W, 4, width of the NZCV set-mask.
- PC_IDX, 15, register index of the PC.
- CNTW, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nreset  in  1  synchronous, active-low reset.
- dec_valid  in  1  decoded instruction present at the fetch/decode output.
- dec_rn_a  in  REGAW  Rn address.
- dec_rn_use  in  1  instruction reads Rn.
- dec_rm_a  in  REGAW  Rm address.
- dec_rm_use  in  1  Rm is read (0 when the Rm bypass/immediate is selected).
- dec_rd_a  in  REGAW  Rd address.
- dec_rd_read  in  1  Rd is read (store data).
- dec_reg_we  in  1  instruction writes Rd.
- dec_set_cpsr  in  FLAGS_W  flag set-mask.
- dec_reads_flags  in  1  condition field is not AL.
- flush  in  1  taken branch resolved in EXEC; squash younger work.
- stall_bits  out  PHASES  bit FETCH_PHASE = issue hold; all other bits 0.
- issue  out  1  `dec_valid` and no hazard and no flush.
- wb_valid  out  1  S4 holds a real instruction.
- wb_rd_a  out  REGAW  Rd of S4.
- wb_we  out  1  S4 valid and writes a register.
- inflight  out  3  count of valid slots S1..S4.
- stall_cnt  out  CNTW  saturating count of hazard cycles.

Behaviour:
- Slot contents: `{valid, rd_a, reg_we, set_cpsr}`.
- Reset (`nreset`=0 at the edge): all slots invalid, `stall_cnt`=0. Combinational outputs then read `stall_bits`=0, `issue`=`dec_valid`, `wb_*`=0, `inflight`=0. Reset mid-operation discards all in-flight entries with no partial commit.
- Every cycle S4<=S3, S3<=S2, S2<=S1. The back end never stalls.
- S1 <= decode entry if `issue`, else a bubble (valid=0).
- raw_hit(a): any of S1..S3 has valid and reg_we and rd_a==a.
  - S4 is excluded: its writeback commits at the end of the current cycle, before the consumer's REG cycle.
- RAW hazard: `dec_valid` and ((`dec_rn_use` and raw_hit(`dec_rn_a`)) or (`dec_rm_use` and raw_hit(`dec_rm_a`)) or (`dec_rd_read` and raw_hit(`dec_rd_a`))).
- Flag hazard: `dec_valid` and `dec_reads_flags` and any of S1..S2 valid with `set_cpsr`!=0. CPSR is written in MEM, which is later than the consumer's EXEC check would need.
- PC hazard: any of S1..S4 valid with reg_we and rd_a==PC_IDX. Hold issue until the slots drain.
- hazard = RAW or flag or PC hazard.
- `stall_bits[FETCH_PHASE]` = hazard and not `flush`.
- `issue` = `dec_valid` and not hazard and not `flush`.
- `flush`=1:
  - S2 <= bubble instead of S1; S1 <= bubble.
  - S3 <= S2 as normal (the branch itself advances).
  - No issue that cycle.
  - Priority: reset > flush > hazard.
- `stall_cnt` increments when `stall_bits[FETCH_PHASE]`=1 and saturates at 2^CNTW-1. No wrap.
- `dec_valid`=0 inserts a bubble, with no stall and no count increment.
- Reads of a register that is also the instruction's own Rd are not a hazard against itself (it is not yet in a slot).

Decomposition:
- Shared defines header: PHASES, FETCH_PHASE/REG_PHASE/EXEC_PHASE/MEM_PHASE/WB_PHASE indices, REGAW, FLAGS_W, PC_i, slot field widths.
- One sub-module: `sb_slot`, a slot register with synchronous active-low clear, a squash input and a load input, instantiated 4 times.
- Hazard compare and the counter stay in the top.

Test Plan:
- Reset: drive `nreset`=0 for 2 cycles with `dec_valid`=1, then release.
  -> `inflight`=0, `stall_cnt`=0, `wb_valid`=0 during reset; `issue`=1 on the first post-reset cycle.
- RAW: issue `ADD r1` (we, rd=1), then `SUB` reading rn=1.
  -> `stall_bits`[0]=1 for exactly 3 cycles; `issue` rises on cycle 4; `stall_cnt`=3.
- Independent: back-to-back writes to r1..r4 with reads of r8.
  -> no stall; `inflight` ramps 1,2,3,4.
  -> `wb_we`=1 with `wb_rd_a`=1,2,3,4 on cycles 4..7.
- Flags: `CMP` (`set_cpsr`=4'hF), then `BEQ` (`reads_flags`=1).
  -> 2 stall cycles.
- Flush: producer of r2 is in S1, branch is in S2; assert `flush` and present a consumer of r2.
  -> next cycle S1 and S2 hold bubbles, S3 holds the branch.
  -> the consumer of r2 issues the following cycle with no RAW stall.
- PC write and saturation: `MOV pc,r0` (rd=15) stalls issue until S4 drains (4 cycles).
  -> force `stall_cnt` to 16'hFFFE and hold a hazard for 3 cycles: it reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants for the issue interlock: phase indices, default
// widths and the register index that aliases the program counter.
package hazard_scoreboard_pkg;

    localparam int PHASES_DEF  = 5;
    localparam int FETCH_PHASE = 0;
    localparam int REG_PHASE   = 1;
    localparam int EXEC_PHASE  = 2;
    localparam int MEM_PHASE   = 3;
    localparam int WB_PHASE    = 4;

    localparam int REGAW_DEF   = 4;
    localparam int FLAGS_W_DEF = 4;
    localparam int PC_I        = 15;
    localparam int CNTW_DEF    = 16;
    localparam int NUM_SLOTS   = 4;

    // Slot layout is {valid, rd_a, reg_we, set_cpsr}.
    function automatic int slot_width(input int regaw, input int flags_w);
        return 1 + regaw + 1 + flags_w;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_slot.sv
// One scoreboard stage: loads its predecessor each cycle, or becomes a bubble
// when squashed; reset clears it so no stale entry can ever commit.
module sb_slot #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         squash,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!nreset)
            q <= '0;
        else if (squash)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue interlock for the 5-phase pipeline: holds fetch on RAW, flag and PC
// hazards (no forwarding) and exposes the WB-slot write qualifiers.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int PHASES  = PHASES_DEF,
    parameter int REGAW   = REGAW_DEF,
    parameter int FLAGS_W = FLAGS_W_DEF,
    parameter int PC_IDX  = PC_I,
    parameter int CNTW    = CNTW_DEF
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               dec_valid,
    input  logic [REGAW-1:0]   dec_rn_a,
    input  logic               dec_rn_use,
    input  logic [REGAW-1:0]   dec_rm_a,
    input  logic               dec_rm_use,
    input  logic [REGAW-1:0]   dec_rd_a,
    input  logic               dec_rd_read,
    input  logic               dec_reg_we,
    input  logic [FLAGS_W-1:0] dec_set_cpsr,
    input  logic               dec_reads_flags,
    input  logic               flush,
    output logic [PHASES-1:0]  stall_bits,
    output logic               issue,
    output logic               wb_valid,
    output logic [REGAW-1:0]   wb_rd_a,
    output logic               wb_we,
    output logic [2:0]         inflight,
    output logic [CNTW-1:0]    stall_cnt
);

    typedef struct packed {
        logic               valid;
        logic [REGAW-1:0]   rd_a;
        logic               reg_we;
        logic [FLAGS_W-1:0] set_cpsr;
    } slot_t;

    localparam logic [REGAW-1:0] PC_A = PC_IDX[REGAW-1:0];

    slot_t          slot_q [NUM_SLOTS];
    slot_t          slot_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_squash;
    slot_t          dec_entry;

    logic rn_hit, rm_hit, rd_hit, flag_busy, pc_busy;
    logic raw_hz, flag_hz, hazard, hold;

    assign dec_entry = '{valid: 1'b1, rd_a: dec_rd_a, reg_we: dec_reg_we,
                         set_cpsr: dec_set_cpsr};

    // Index 0 is S1 (REG) ... index 3 is S4 (WB). S4 is left out of the RAW
    // compare because its writeback lands before the consumer reads.
    always_comb begin
        rn_hit    = 1'b0;
        rm_hit    = 1'b0;
        rd_hit    = 1'b0;
        flag_busy = 1'b0;
        pc_busy   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (slot_q[i].valid && slot_q[i].reg_we) begin
                if (slot_q[i].rd_a == dec_rn_a) rn_hit = 1'b1;
                if (slot_q[i].rd_a == dec_rm_a) rm_hit = 1'b1;
                if (slot_q[i].rd_a == dec_rd_a) rd_hit = 1'b1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (slot_q[i].valid && (|slot_q[i].set_cpsr)) flag_busy = 1'b1;
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_q[i].valid && slot_q[i].reg_we && slot_q[i].rd_a == PC_A)
                pc_busy = 1'b1;
        end
    end

    assign raw_hz  = dec_valid && ((dec_rn_use && rn_hit) ||
                                   (dec_rm_use && rm_hit) ||
                                   (dec_rd_read && rd_hit));
    assign flag_hz = dec_valid && dec_reads_flags && flag_busy;
    assign hazard  = raw_hz || flag_hz || pc_busy;
    assign hold    = hazard && !flush;
    assign issue   = dec_valid && !hazard && !flush;

    always_comb begin
        stall_bits              = '0;
        stall_bits[FETCH_PHASE] = hold;
    end

    // A flush bubbles both S1 and S2; the branch itself sits in S2 and moves on.
    always_comb begin
        slot_d[0] = dec_entry;
        for (int i = 1; i < NUM_SLOTS; i++) slot_d[i] = slot_q[i-1];
        slot_squash    = '0;
        slot_squash[0] = !issue;
        slot_squash[1] = flush;
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        sb_slot #(.W($bits(slot_t))) u_slot (
            .clk    (clk),
            .nreset (nreset),
            .squash (slot_squash[g]),
            .load   (1'b1),
            .d      (slot_d[g]),
            .q      (slot_q[g])
        );
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            inflight = inflight + {2'b00, slot_q[i].valid};
    end

    assign wb_valid = slot_q[NUM_SLOTS-1].valid;
    assign wb_rd_a  = slot_q[NUM_SLOTS-1].rd_a;
    assign wb_we    = slot_q[NUM_SLOTS-1].valid && slot_q[NUM_SLOTS-1].reg_we;

    always_ff @(posedge clk) begin
        if (!nreset)
            stall_cnt <= '0;
        else if (hold && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNTW'(1);
    end

endmodule
